// File: rtl/cu_sequencer.sv
// Multi-cycle control-unit sequencer for the 19-bit CPU.
// Fetch/decode/execute FSM with registered Moore strobes and a memory watchdog.
module cu_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int TCNT_W  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [4:0] opcode,
  input  logic [3:0] flags,
  input  logic       mem_ready,
  output logic       rd_en,
  output logic       wr_en,
  output logic       inc_pc,
  output logic       load_reg,
  output logic [2:0] load_select,
  output logic       mode,
  output logic       mux_select_a,
  output logic       mux_select_b,
  output logic [3:0] flags_q,
  output logic       busy,
  output logic       halted,
  output logic       fault
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_FETCH_DONE, S_DECODE,
    S_EXEC, S_ALU_WB, S_MEM_RD, S_MEM_WB,
    S_MEM_WR, S_BRANCH, S_NEXT, S_HALT,
    S_FAULT
  } state_t;

  localparam logic [TCNT_W-1:0] TLIM = TCNT_W'(TIMEOUT);

  state_t state, nxt;
  logic [TCNT_W-1:0] tcnt, tcnt_inc;
  logic req, expired;
  logic is_alu, is_ld, is_st, is_halt, taken;
  logic rd_d, wr_d, inc_d, ld_d, mode_d, ma_d, mb_d;
  logic [2:0] sel_d;

  assign req = (state == S_FETCH) || (state == S_MEM_RD) ||
               (state == S_MEM_WR);
  assign tcnt_inc = tcnt + 1'b1;
  assign expired = (tcnt_inc == TLIM);

  assign is_alu  = !opcode[4] && (|opcode[3:0]);
  assign is_ld   = (opcode == 5'b10000);
  assign is_st   = (opcode == 5'b10001);
  assign is_halt = (opcode == 5'b11111);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      5'b10010: taken = 1'b1;
      5'b10011: taken = flags[0];
      5'b10100: taken = !flags[0];
      5'b10101: taken = flags[1];
      5'b10110: taken = flags[2];
      default:  taken = 1'b0;
    endcase
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (enable) nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ready) nxt = S_FETCH_DONE;
        else if (expired) nxt = S_FAULT;
      end
      S_FETCH_DONE: nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_alu:  nxt = S_EXEC;
          is_ld:   nxt = S_MEM_RD;
          is_st:   nxt = S_MEM_WR;
          taken:   nxt = S_BRANCH;
          is_halt: nxt = S_HALT;
          default: nxt = S_NEXT;
        endcase
      end
      S_EXEC:   nxt = S_ALU_WB;
      S_ALU_WB: nxt = S_NEXT;
      S_MEM_RD: begin
        if (mem_ready) nxt = S_MEM_WB;
        else if (expired) nxt = S_FAULT;
      end
      S_MEM_WB: nxt = S_NEXT;
      S_MEM_WR: begin
        if (mem_ready) nxt = S_NEXT;
        else if (expired) nxt = S_FAULT;
      end
      S_BRANCH: nxt = S_NEXT;
      S_NEXT:   nxt = enable ? S_FETCH : S_IDLE;
      S_HALT:   if (!enable) nxt = S_IDLE;
      S_FAULT:  nxt = S_FAULT;
      default:  nxt = S_IDLE;
    endcase
  end

  // strobes are decoded from the next state so they line up with it
  always_comb begin
    rd_d   = 1'b0;
    wr_d   = 1'b0;
    inc_d  = 1'b0;
    ld_d   = 1'b0;
    sel_d  = 3'b000;
    mode_d = 1'b0;
    ma_d   = 1'b0;
    mb_d   = 1'b0;
    unique case (nxt)
      S_FETCH: rd_d = 1'b1;
      S_FETCH_DONE: begin
        ld_d  = 1'b1;
        sel_d = 3'b001;
        inc_d = 1'b1;
      end
      S_EXEC: mode_d = opcode[3];
      S_ALU_WB: begin
        ld_d   = 1'b1;
        sel_d  = 3'b100;
        mode_d = mode;
      end
      S_MEM_RD: begin
        rd_d = 1'b1;
        ma_d = 1'b1;
        mb_d = 1'b1;
      end
      S_MEM_WB: begin
        ld_d  = 1'b1;
        sel_d = 3'b100;
        mb_d  = 1'b1;
      end
      S_MEM_WR: begin
        wr_d = 1'b1;
        ma_d = 1'b1;
      end
      S_BRANCH: ld_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      tcnt         <= '0;
      rd_en        <= 1'b0;
      wr_en        <= 1'b0;
      inc_pc       <= 1'b0;
      load_reg     <= 1'b0;
      load_select  <= 3'b000;
      mode         <= 1'b0;
      mux_select_a <= 1'b0;
      mux_select_b <= 1'b0;
      flags_q      <= 4'b0000;
      busy         <= 1'b0;
      halted       <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= nxt;
      rd_en        <= rd_d;
      wr_en        <= wr_d;
      inc_pc       <= inc_d;
      load_reg     <= ld_d;
      load_select  <= sel_d;
      mode         <= mode_d;
      mux_select_a <= ma_d;
      mux_select_b <= mb_d;
      busy         <= (nxt != S_IDLE) && (nxt != S_HALT) &&
                      (nxt != S_FAULT);
      halted       <= (nxt == S_HALT);
      fault        <= (nxt == S_FAULT);
      if (nxt != state) tcnt <= '0;
      else if (req && !mem_ready) tcnt <= tcnt_inc;
      if (state == S_ALU_WB) flags_q <= flags;
    end
  end

endmodule

// File: tb/tb_cu_sequencer.sv
// Scoreboard bench for cu_sequencer: expectations are queued with
// the stimulus and popped when the observed instruction completes.
module tb_cu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic [3:0] flags = 4'd0;
  logic       mem_ready = 1'b1;
  logic       rd_en, wr_en, inc_pc, load_reg;
  logic [2:0] load_select;
  logic       mode, mux_select_a, mux_select_b;
  logic [3:0] flags_q;
  logic       busy, halted, fault;

  int total = 0;
  int bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  cu_sequencer #(.TIMEOUT(16), .TCNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .opcode(opcode), .flags(flags), .mem_ready(mem_ready),
    .rd_en(rd_en), .wr_en(wr_en), .inc_pc(inc_pc),
    .load_reg(load_reg), .load_select(load_select),
    .mode(mode), .mux_select_a(mux_select_a),
    .mux_select_b(mux_select_b), .flags_q(flags_q),
    .busy(busy), .halted(halted), .fault(fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rd_en && !mux_select_a) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic go_idle(output bit ok);
    enable = 0;
    mem_ready = 1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!busy && !halted) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Called while sampling the first FETCH cycle of an instruction;
  // returns at the next FETCH entry or when busy drops.
  task automatic observe(
    input  int mem_wait, input bit drop_en,
    output int lat, output int n_ir, output int n_ld,
    output int sel, output int md, output int n_rd,
    output int n_rdb, output int n_wr);
    int ow;
    bit prev;
    ow = 0; prev = 1;
    lat = 0; n_ir = 0; n_ld = 0; sel = 0; md = 0;
    n_rd = 0; n_rdb = 0; n_wr = 0;
    mem_ready = 1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (rd_en && !mux_select_a && !prev) begin
        lat = k;
        break;
      end
      if (!busy) begin
        lat = k;
        break;
      end
      prev = rd_en && !mux_select_a;
      if (load_reg && load_select == 3'b001 && inc_pc) n_ir++;
      else if (load_reg) begin
        n_ld++;
        sel = int'(load_select);
        md = int'(mode);
      end
      if (rd_en && mux_select_a) begin
        n_rd++;
        if (mux_select_b) n_rdb++;
      end
      if (wr_en) n_wr++;
      if ((rd_en || wr_en) && mux_select_a) begin
        mem_ready = (ow >= mem_wait);
        ow++;
        if (drop_en) enable = 0;
      end else begin
        mem_ready = 1;
      end
    end
    mem_ready = 1;
  endtask

  task automatic test_reset();
    int e;
    rst_n = 0;
    #1;
    exp_q.push_back(0);
    e = exp_q.pop_front();
    total++;
    if ({rd_en, wr_en, inc_pc, load_reg, load_select, mode,
         mux_select_a, mux_select_b, flags_q, busy, halted,
         fault} !== 18'(e)) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0",
        {rd_en, wr_en, inc_pc, load_reg, load_select, mode,
         mux_select_a, mux_select_b, flags_q, busy, halted, fault});
    end
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic run_instr(input string tag, input int mem_wait,
      input bit drop_en);
    int lat, n_ir, n_ld, sel, md, n_rd, n_rdb, n_wr, e;
    int got[$];
    string nm[$];
    observe(mem_wait, drop_en, lat, n_ir, n_ld, sel, md,
            n_rd, n_rdb, n_wr);
    got = '{lat, n_ir, n_ld, sel, md, n_rd, n_rdb, n_wr};
    nm = '{"lat", "ir_load", "exec_load", "load_sel", "mode",
           "rd_cycles", "rd_mux_b", "wr_cycles"};
    foreach (got[i]) begin
      e = exp_q.pop_front();
      total++;
      if (got[i] !== e) begin
        bad++;
        $display("FAIL %s.%s: got %0d want %0d", tag, nm[i],
          got[i], e);
      end
    end
  endtask

  task automatic push_exp(input int lat, input int n_ld,
      input int sel, input int md, input int n_rd, input int n_wr);
    exp_q.push_back(lat);
    exp_q.push_back(1);
    exp_q.push_back(n_ld);
    exp_q.push_back(sel);
    exp_q.push_back(md);
    exp_q.push_back(n_rd);
    exp_q.push_back(n_rd);
    exp_q.push_back(n_wr);
  endtask

  task automatic check_start(input string tag);
    bit ok;
    enable = 1;
    mem_ready = 1;
    wait_fetch(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s.start: got no fetch want fetch", tag);
    end
  endtask

  task automatic check_idle(input string tag);
    bit ok;
    go_idle(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s.idle: got busy=%0d want 0", tag, busy);
    end
  endtask

  task automatic test_alu();
    opcode = 5'b00101;
    flags = 4'b0011;
    push_exp(6, 1, 4, 0, 0, 0);
    check_start("alu");
    run_instr("alu_add", 0, 0);
    total++;
    if (flags_q !== 4'b0011) begin
      bad++;
      $display("FAIL alu_add.flags_q: got %b want 0011", flags_q);
    end
    opcode = 5'b01101;
    flags = 4'b0100;
    push_exp(6, 1, 4, 1, 0, 0);
    run_instr("alu_logic", 0, 0);
    total++;
    if (flags_q !== 4'b0100) begin
      bad++;
      $display("FAIL alu_logic.flags_q: got %b want 0100", flags_q);
    end
    check_idle("alu");
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 0;
    opcode = 5'b10000;
    check_start("rst_mid");
    for (int i = 0; i < 20; i++) begin
      mem_ready = !(rd_en && mux_select_a);
      if (rd_en && mux_select_a) begin
        hit = 1;
        break;
      end
      tick();
    end
    #2;
    rst_n = 0;
    #1;
    total++;
    if (!hit || rd_en !== 1'b0 || busy !== 1'b0 ||
        flags_q !== 4'b0000 || mux_select_a !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: got hit=%0d rd_en=%0d busy=%0d fq=%b want 1 0 0 0000",
        hit, rd_en, busy, flags_q);
    end
    enable = 0;
    mem_ready = 1;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_nop_branch();
    logic [4:0] ops[8] = '{5'b00000, 5'b11000, 5'b10011, 5'b10011,
                           5'b10100, 5'b10101, 5'b10110, 5'b10010};
    logic [3:0] fl[8] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000,
                          4'b0000, 4'b0000, 4'b0100, 4'b0000};
    int tk[8] = '{0, 0, 1, 0, 1, 0, 1, 1};
    opcode = ops[0];
    flags = fl[0];
    check_start("br");
    for (int i = 0; i < 8; i++) begin
      opcode = ops[i];
      flags = fl[i];
      push_exp(tk[i] ? 5 : 4, tk[i], 0, 0, 0, 0);
      run_instr($sformatf("br%0d", i), 0, 0);
    end
    check_idle("br");
  endtask

  task automatic test_load_wait();
    opcode = 5'b10000;
    push_exp(9, 1, 4, 0, 4, 0);
    check_start("load");
    run_instr("load_w3", 3, 0);
    check_idle("load");
  endtask

  task automatic test_store();
    opcode = 5'b10001;
    push_exp(5, 0, 0, 0, 0, 1);
    check_start("store");
    run_instr("store_w0", 0, 0);
    push_exp(20, 0, 0, 0, 0, 16);
    run_instr("store_w15", 15, 0);
    total++;
    if (fault !== 1'b0) begin
      bad++;
      $display("FAIL store_w15.fault: got %0d want 0", fault);
    end
    check_idle("store");
  endtask

  task automatic test_back_to_back();
    logic [4:0] ops[5] = '{5'b00011, 5'b10000, 5'b10001,
                           5'b00000, 5'b10010};
    int waits[5] = '{0, 1, 0, 0, 0};
    opcode = ops[0];
    push_exp(6, 1, 4, 0, 0, 0);
    push_exp(7, 1, 4, 0, 2, 0);
    push_exp(5, 0, 0, 0, 0, 1);
    push_exp(4, 0, 0, 0, 0, 0);
    push_exp(5, 1, 0, 0, 0, 0);
    check_start("b2b");
    for (int i = 0; i < 5; i++) begin
      opcode = ops[i];
      run_instr($sformatf("b2b%0d", i), waits[i], 0);
    end
    check_idle("b2b");
  endtask

  task automatic test_enable_drop();
    int rds;
    rds = 0;
    opcode = 5'b10001;
    exp_q.push_back(7);
    exp_q.push_back(1);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(3);
    check_start("drop");
    run_instr("drop_st", 2, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rd_en || busy) rds++;
    end
    total++;
    if (rds !== 0) begin
      bad++;
      $display("FAIL drop.no_refetch: got %0d active cycles want 0", rds);
    end
  endtask

  task automatic test_halt();
    opcode = 5'b11111;
    exp_q.push_back(3);
    exp_q.push_back(1);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
    check_start("halt");
    run_instr("halt", 0, 0);
    tick();
    tick();
    total++;
    if (halted !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL halt.hold: got halted=%0d busy=%0d want 1 0",
        halted, busy);
    end
    enable = 0;
    tick();
    total++;
    if (halted !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL halt.exit: got halted=%0d busy=%0d want 0 0",
        halted, busy);
    end
  endtask

  task automatic test_timeout();
    opcode = 5'b10001;
    exp_q.push_back(19);
    exp_q.push_back(1);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(16);
    check_start("tmo");
    run_instr("tmo", 1000, 0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (fault !== 1'b1 || busy !== 1'b0 ||
          {rd_en, wr_en, inc_pc, load_reg} !== 4'b0000) begin
        bad++;
        $display("FAIL tmo.fault%0d: got fault=%0d busy=%0d strobes=%b want 1 0 0000",
          i, fault, busy, {rd_en, wr_en, inc_pc, load_reg});
      end
      mem_ready = 1;
      tick();
    end
    rst_n = 0;
    #1;
    total++;
    if (fault !== 1'b0) begin
      bad++;
      $display("FAIL tmo.reset: got fault=%0d want 0", fault);
    end
    enable = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_reset_mid();
    test_nop_branch();
    test_load_wait();
    test_store();
    test_back_to_back();
    test_enable_drop();
    test_halt();
    test_timeout();
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_left: got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
